// File: rtl/shadow_spill_ctrl.sv
// shadow_spill_ctrl: manages the 16-entry shadow register bank for fast interrupt
// entry/exit. On entry it strobes the shadow save and spills the bank to the stack
// frame in the background; on mret it refills the bank from the frame and strobes
// the shadow-to-architectural load.
// Optional frame-depth checking: define SHADOW_SPILL_DEPTH_CHK_EN.
module shadow_spill_ctrl #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned NR_SHADOW       = 16,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            entry_req_i,
  output logic            entry_gnt_o,
  input  logic            mret_req_i,
  output logic            mret_gnt_o,
  output logic            mret_done_o,
`ifdef SHADOW_SPILL_DEPTH_CHK_EN
  output logic            depth_err_o,
`endif
  output logic            busy_o,
  output logic            shadow_save_o,
  input  logic [XLEN-1:0] next_sp_i,
  input  logic [XLEN-1:0] shadow_sp_i,
  output logic [3:0]      shadow_raddr_o,
  input  logic [XLEN-1:0] shadow_rdata_i,
  output logic [3:0]      shadow_waddr_o,
  output logic [XLEN-1:0] shadow_wdata_o,
  output logic            shadow_we_o,
  output logic            shadow_load_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned WORD_BYTES = XLEN / 8;
  localparam int unsigned CNT_W      = $clog2(NR_SHADOW + 1);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned DEPTH_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2,
    LOAD  = 2'd3
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [XLEN-1:0]   base_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  resp_cnt_q;
  logic [OUT_W-1:0]  outstanding_q;
  logic [OUT_W-1:0]  outstanding_d;

  logic              spill_start;
  logic              fill_start;
  logic              spill_done;
  logic              issue_ok;
  logic              issue_fire;
  logic              resp_ok;
  logic              last_resp;
  logic              entry_allow;
  logic              fill_allow;
  logic [XLEN-1:0]   addr_c;

`ifdef SHADOW_SPILL_DEPTH_CHK_EN
  logic [DEPTH_W-1:0] depth_q;

  assign entry_allow = (depth_q != {DEPTH_W{1'b1}});
  assign fill_allow  = (depth_q != DEPTH_W'(0));
`else
  assign entry_allow = 1'b1;
  assign fill_allow  = 1'b1;
`endif

  // Request issue is throttled by the outstanding window and by the frame length.
  assign issue_ok   = (issue_cnt_q != CNT_W'(NR_SHADOW)) &&
                      (outstanding_q != OUT_W'(MAX_OUTSTANDING));
  assign issue_fire = mem_req_o & mem_gnt_i;
  // Responses arriving with nothing in flight are stray and ignored.
  assign resp_ok    = mem_rvalid_i & (outstanding_q != OUT_W'(0));
  assign last_resp  = resp_ok && (resp_cnt_q == CNT_W'(NR_SHADOW - 1));
  // Frame word address; wraps modulo 2^XLEN.
  assign addr_c     = base_q + (XLEN'(issue_cnt_q) * XLEN'(WORD_BYTES));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    entry_gnt_o    = 1'b0;
    mret_gnt_o     = 1'b0;
    mret_done_o    = 1'b0;
`ifdef SHADOW_SPILL_DEPTH_CHK_EN
    depth_err_o    = 1'b0;
`endif
    busy_o         = 1'b0;
    shadow_save_o  = 1'b0;
    shadow_raddr_o = '0;
    shadow_waddr_o = '0;
    shadow_wdata_o = '0;
    shadow_we_o    = 1'b0;
    shadow_load_o  = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    spill_start    = 1'b0;
    fill_start     = 1'b0;
    spill_done     = 1'b0;

    case (state_q)
      IDLE: begin
        entry_gnt_o   = entry_req_i & entry_allow;
        mret_gnt_o    = mret_req_i & ~entry_req_i;
        shadow_save_o = entry_gnt_o;
        if (entry_gnt_o) begin
          spill_start = 1'b1;
          state_d     = SPILL;
        end else if (mret_gnt_o) begin
          if (fill_allow) begin
            fill_start = 1'b1;
            state_d    = FILL;
          end
`ifdef SHADOW_SPILL_DEPTH_CHK_EN
          else begin
            depth_err_o = 1'b1;
          end
`endif
        end
      end

      SPILL: begin
        busy_o         = 1'b1;
        mem_req_o      = issue_ok;
        mem_we_o       = 1'b1;
        mem_addr_o     = addr_c;
        shadow_raddr_o = issue_cnt_q[IDX_W-1:0];
        mem_wdata_o    = shadow_rdata_i;
        if (last_resp) begin
          spill_done = 1'b1;
          state_d    = IDLE;
        end
      end

      FILL: begin
        busy_o         = 1'b1;
        mem_req_o      = issue_ok;
        mem_addr_o     = addr_c;
        shadow_we_o    = resp_ok;
        shadow_waddr_o = resp_cnt_q[IDX_W-1:0];
        shadow_wdata_o = mem_rdata_i;
        if (last_resp) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        busy_o        = 1'b1;
        shadow_load_o = 1'b1;
        mret_done_o   = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding-request bookkeeping: +1 per grant, -1 per accepted response.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_fire && !resp_ok) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!issue_fire && resp_ok) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  // Frame base, issue/response indices and in-flight count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q        <= '0;
      issue_cnt_q   <= '0;
      resp_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (spill_start) begin
        base_q <= next_sp_i;
      end else if (fill_start) begin
        base_q <= shadow_sp_i;
      end
      if (spill_start || fill_start) begin
        issue_cnt_q <= '0;
        resp_cnt_q  <= '0;
      end else begin
        if (issue_fire) begin
          issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        end
        if (resp_ok) begin
          resp_cnt_q <= resp_cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef SHADOW_SPILL_DEPTH_CHK_EN
  // Frame depth: one more frame per completed spill, one fewer per restore.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
    end else if (spill_done) begin
      depth_q <= depth_q + DEPTH_W'(1);
    end else if (state_q == LOAD) begin
      depth_q <= depth_q - DEPTH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_shadow_spill_ctrl.sv
// Bench for shadow_spill_ctrl: a randomized memory with random grant/response
// timing, a register-file shadow bank model and a frame memory model supply the
// expected traffic and restored values.
module tb_shadow_spill_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NR   = 16;
  localparam int unsigned MAXO = 2;
  localparam int unsigned WB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            entry_req, entry_gnt, mret_req, mret_gnt, mret_done;
  logic            busy, shadow_save, shadow_we, shadow_load;
  logic [XLEN-1:0] next_sp, shadow_sp, shadow_rdata, shadow_wdata;
  logic [3:0]      shadow_raddr, shadow_waddr;
  logic            mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
`ifdef SHADOW_SPILL_DEPTH_CHK_EN
  logic            depth_err;
`endif

  logic [XLEN-1:0] bank [NR];
  assign shadow_rdata = bank[shadow_raddr];

  shadow_spill_ctrl #(.XLEN(XLEN), .NR_SHADOW(NR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .entry_req_i(entry_req), .entry_gnt_o(entry_gnt),
    .mret_req_i(mret_req), .mret_gnt_o(mret_gnt), .mret_done_o(mret_done),
`ifdef SHADOW_SPILL_DEPTH_CHK_EN
    .depth_err_o(depth_err),
`endif
    .busy_o(busy), .shadow_save_o(shadow_save),
    .next_sp_i(next_sp), .shadow_sp_i(shadow_sp),
    .shadow_raddr_o(shadow_raddr), .shadow_rdata_i(shadow_rdata),
    .shadow_waddr_o(shadow_waddr), .shadow_wdata_o(shadow_wdata),
    .shadow_we_o(shadow_we), .shadow_load_o(shadow_load),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tb_outs, save_cnt, load_cnt, done_cnt, stall_cycles;
  logic [XLEN-1:0] mem [logic [XLEN-1:0]];
  logic [XLEN-1:0] resp_q [$];
  logic [XLEN-1:0] wr_addr_q [$];
  logic [XLEN-1:0] wr_data_q [$];
  logic [XLEN-1:0] rd_addr_q [$];
  logic [XLEN-1:0] sh_data_q [$];
  logic [3:0]      sh_idx_q [$];
  logic            prev_pending, prev_we;
  logic [XLEN-1:0] prev_addr, prev_wdata;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{entry_gnt, mret_gnt, mret_done, busy, shadow_save, shadow_raddr, shadow_waddr,
             shadow_wdata, shadow_we, shadow_load, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  // Observe one cycle of DUT outputs (called on the falling edge).
  task automatic sample();
    if (shadow_save) save_cnt++;
    if (shadow_load) load_cnt++;
    if (mret_done) begin
      done_cnt++;
      check_eq("done_with_load", 64'(shadow_load), 64'(1));
      check_eq("writes_before_load", 64'(sh_idx_q.size()), 64'(NR));
    end
    if (shadow_we) begin
      sh_idx_q.push_back(shadow_waddr);
      sh_data_q.push_back(shadow_wdata);
    end
    if (prev_pending) begin
      check_eq("stall_req_held", 64'(mem_req), 64'(1));
      check_eq("stall_addr_held", mem_addr, prev_addr);
      check_eq("stall_we_held", 64'(mem_we), 64'(prev_we));
      check_eq("stall_wdata_held", mem_wdata, prev_wdata);
    end
    if (mem_req && mem_gnt) begin
      check_eq("outstanding_limit", 64'(tb_outs < int'(MAXO)), 64'(1));
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        mem[mem_addr] = mem_wdata;
        resp_q.push_back('0);
      end else begin
        rd_addr_q.push_back(mem_addr);
        resp_q.push_back(mem.exists(mem_addr) ? mem[mem_addr] : '0);
      end
      tb_outs++;
    end
    if (mem_rvalid) tb_outs--;
    prev_pending = mem_req & ~mem_gnt;
    prev_addr    = mem_addr;
    prev_wdata   = mem_wdata;
    prev_we      = mem_we;
  endtask

  // Random grant and in-order, random-latency responses.
  task automatic drive_mem();
    if (stall_cycles > 0) begin
      mem_gnt = 1'b0;
      stall_cycles--;
    end else begin
      mem_gnt = ($urandom_range(0, 99) < 70);
    end
    if (resp_q.size() > 0 && $urandom_range(0, 99) < 60) begin
      mem_rvalid = 1'b1;
      mem_rdata  = resp_q.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic run_spill(input logic [XLEN-1:0] sp, input bit do_stall, input bit contend);
    int n;
    bit stalled;
    logic [XLEN-1:0] exp_word [NR];
    wr_addr_q.delete();
    wr_data_q.delete();
    save_cnt = 0;
    for (int k = 0; k < int'(NR); k++) begin
      bank[k]     = {$urandom, $urandom};
      exp_word[k] = bank[k];
    end
    next_sp   = sp;
    entry_req = 1'b1;
    mret_req  = contend;
    #1;
    check_eq("entry_gnt", 64'(entry_gnt), 64'(1));
    check_eq("save_strobe", 64'(shadow_save), 64'(1));
    if (contend) check_eq("mret_loses_to_entry", 64'(mret_gnt), 64'(0));
    tick();
    mret_req  = 1'b0;
    entry_req = contend;
    n = 0;
    stalled = 0;
    while (busy && n < 400) begin
      if (contend) check_eq("entry_blocked_busy", 64'(entry_gnt), 64'(0));
      if (do_stall && !stalled && wr_addr_q.size() >= 6) begin
        stall_cycles = 5;
        mem_gnt      = 1'b0;
        stalled      = 1;
      end
      tick();
      n++;
    end
    check_eq("spill_timeout", 64'(n < 400), 64'(1));
    if (contend) begin
      check_eq("entry_gnt_back_in_idle", 64'(entry_gnt), 64'(1));
      entry_req = 1'b0;
    end
    check_eq("spill_write_count", 64'(wr_addr_q.size()), 64'(NR));
    for (int k = 0; k < int'(NR) && k < wr_addr_q.size(); k++) begin
      check_eq("spill_addr", wr_addr_q[k], sp + 64'(k * int'(WB)));
      check_eq("spill_data", wr_data_q[k], exp_word[k]);
    end
    check_eq("save_pulses", 64'(save_cnt), 64'(1));
  endtask

  // mode 0: frame holds 0xA0+i, 1: random frame, 2: frame as left in memory.
  task automatic run_fill(input logic [XLEN-1:0] sp, input int mode, input int reset_after);
    int n;
    bit aborted;
    logic [XLEN-1:0] exp_word [NR];
    for (int i = 0; i < int'(NR); i++) begin
      if (mode == 0) mem[sp + 64'(i * int'(WB))] = 64'(32'hA0 + i);
      else if (mode == 1) mem[sp + 64'(i * int'(WB))] = {$urandom, $urandom};
      exp_word[i] = mem.exists(sp + 64'(i * int'(WB))) ? mem[sp + 64'(i * int'(WB))] : '0;
    end
    rd_addr_q.delete();
    sh_idx_q.delete();
    sh_data_q.delete();
    load_cnt = 0;
    done_cnt = 0;
    shadow_sp = sp;
    mret_req  = 1'b1;
    #1;
    check_eq("mret_gnt", 64'(mret_gnt), 64'(1));
    check_eq("no_save_on_mret", 64'(shadow_save), 64'(0));
    tick();
    mret_req = 1'b0;
    n = 0;
    aborted = 0;
    while (busy && n < 400 && !aborted) begin
      if (reset_after >= 0 && sh_idx_q.size() == reset_after) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_mem_req", 64'(mem_req), 64'(0));
        check_eq("rst_all_outputs", 64'(any_out()), 64'(0));
        resp_q.delete();
        tb_outs      = 0;
        prev_pending = 1'b0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        tick();
        n++;
      end
    end
    if (aborted) begin
      repeat (3) tick();
      check_eq("post_rst_idle", 64'(busy), 64'(0));
      check_eq("post_rst_no_load", 64'(load_cnt), 64'(0));
      check_eq("post_rst_no_done", 64'(done_cnt), 64'(0));
    end else begin
      check_eq("fill_timeout", 64'(n < 400), 64'(1));
      check_eq("fill_read_count", 64'(rd_addr_q.size()), 64'(NR));
      for (int i = 0; i < int'(NR) && i < rd_addr_q.size(); i++)
        check_eq("fill_addr", rd_addr_q[i], sp + 64'(i * int'(WB)));
      check_eq("shadow_write_count", 64'(sh_idx_q.size()), 64'(NR));
      for (int i = 0; i < int'(NR) && i < sh_idx_q.size(); i++) begin
        check_eq("shadow_waddr", 64'(sh_idx_q[i]), 64'(i));
        check_eq("shadow_wdata", sh_data_q[i], exp_word[i]);
      end
      check_eq("load_pulses", 64'(load_cnt), 64'(1));
      check_eq("done_pulses", 64'(done_cnt), 64'(1));
    end
  endtask

  initial begin
    logic [XLEN-1:0] sp;
    rst_n = 1'b0;
    entry_req = 1'b0; mret_req = 1'b0;
    next_sp = '0; shadow_sp = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tb_outs = 0; save_cnt = 0; load_cnt = 0; done_cnt = 0; stall_cycles = 0;
    prev_pending = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    for (int k = 0; k < int'(NR); k++) bank[k] = '0;
    #2;
    check_eq("reset_all_outputs", 64'(any_out()), 64'(0));
    check_eq("reset_busy", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_reset", 64'(busy), 64'(0));

`ifdef SHADOW_SPILL_DEPTH_CHK_EN
    load_cnt = 0;
    mret_req = 1'b1;
    #1;
    check_eq("depth0_mret_gnt", 64'(mret_gnt), 64'(1));
    check_eq("depth0_err", 64'(depth_err), 64'(1));
    check_eq("depth0_no_req", 64'(mem_req), 64'(0));
    tick();
    mret_req = 1'b0;
    #1;
    check_eq("depth0_err_one_cycle", 64'(depth_err), 64'(0));
    check_eq("depth0_idle", 64'(busy), 64'(0));
    check_eq("depth0_no_load", 64'(load_cnt), 64'(0));
`endif

    // Stray response with nothing outstanding.
    mem_rvalid = 1'b1;
    @(negedge clk);
    check_eq("stray_rvalid_idle", 64'(busy), 64'(0));
    check_eq("stray_rvalid_no_we", 64'(shadow_we), 64'(0));
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;

    run_spill(64'hF80, 1'b1, 1'b0);
    run_fill(64'hF80, 0, -1);

    sp = {$urandom, $urandom} & ~64'h7;
    run_spill(sp, 1'b0, 1'b1);
    run_fill(sp, 2, -1);

    for (int it = 0; it < 3; it++) begin
      sp = {$urandom, $urandom} & ~64'h7;
      run_spill(sp, 1'($urandom_range(0, 1)), 1'b0);
      run_fill(sp, 1, -1);
    end

    run_spill(64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b0);
    run_fill(64'hFFFF_FFFF_FFFF_FFC0, 2, -1);

    run_spill(64'h2000, 1'b0, 1'b0);
    run_fill(64'h2000, 1, 7);

    run_spill(64'h3000, 1'b0, 1'b0);
    run_fill(64'h3000, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shadow_spill_ctrl.md
Name: shadow_spill_ctrl

Overview:
- Controller that sits beside the integer register file and manages its 16-entry shadow bank for fast interrupt entry and exit.
- On interrupt entry it triggers the shadow save, then spills the 16 shadowed words to the stack frame through a data-memory port, in the background.
- On mret it refills the shadow bank from the stack frame, pulses the shadow load into the architectural registers, and signals completion.

Parameters:
- XLEN, 64, data and address width in bits.
- NR_SHADOW, 16, shadow words per frame; fixed to 16 to match the register file.
- MAX_OUTSTANDING, 2, maximum memory requests granted but not yet answered (1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- entry_req_i  in  1  interrupt entry request
- entry_gnt_o  out  1  entry accepted (combinational)
- mret_req_i  in  1  return request
- mret_gnt_o  out  1  return accepted (combinational)
- mret_done_o  out  1  one-cycle pulse: architectural registers restored
- busy_o  out  1  spill or fill in progress
- shadow_save_o  out  1  register file shadow save strobe
- next_sp_i  in  XLEN  stack pointer value after the save decrement
- shadow_sp_i  in  XLEN  current architectural sp
- shadow_raddr_o  out  4  shadow read index
- shadow_rdata_i  in  XLEN  shadow read data
- shadow_waddr_o  out  4  shadow write index
- shadow_wdata_o  out  XLEN  shadow write data
- shadow_we_o  out  1  shadow write enable
- shadow_load_o  out  1  shadow-to-architectural load strobe
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  XLEN  byte address
- mem_wdata_o  out  XLEN  write data
- mem_rvalid_i  in  1  response; one per granted request, in order
- mem_rdata_i  in  XLEN  read data

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; issue, response and frame counters cleared; any memory responses in flight are dropped.
- Word size W = XLEN/8 bytes. Frame size = 16·W.
- States: IDLE, SPILL, FILL, LOAD.
- IDLE:
  - entry_gnt_o = entry_req_i.
  - mret_gnt_o = mret_req_i & ~entry_req_i (entry wins when both are asserted).
- Entry accept:
  - shadow_save_o = 1 in the same cycle.
  - Latch base = next_sp_i.
  - Next cycle go to SPILL.
- SPILL:
  - Issue index k goes 0..15; each request is a write with mem_addr_o = base + k·W.
  - shadow_raddr_o = k; mem_wdata_o = shadow_rdata_i.
  - k advances on mem_req_o & mem_gnt_i.
  - mem_req_o is held low while outstanding = MAX_OUTSTANDING or k = 16.
  - After the 16th mem_rvalid_i, go to IDLE.
- FILL (entered on mret accept):
  - Latch base = shadow_sp_i.
  - Issue reads at base + k·W, k = 0..15, under the same outstanding rule.
  - Response index r (0..15) counts rvalids. Each response drives shadow_we_o = 1, shadow_waddr_o = r, shadow_wdata_o = mem_rdata_i in the same cycle.
  - After r reaches 16, go to LOAD.
- LOAD: shadow_load_o = 1 for exactly one cycle (the register file adds 16·W to sp); mret_done_o pulses the same cycle; next state IDLE.
- busy_o = 1 in SPILL, FILL and LOAD.
- Entry and mret are never granted outside IDLE; requesters hold their requests.
- The shadow bank is never overwritten before its spill completes.
- Address arithmetic is modulo 2^XLEN (wrap-around permitted, no fault).
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable while mem_req_o & ~mem_gnt_i.
- An rvalid with no outstanding request is ignored.

Optional Feature:
- Macro SHADOW_SPILL_DEPTH_CHK_EN.
- Defined:
  - Adds a 5-bit frame-depth counter: +1 at spill completion, −1 at LOAD.
  - mret requested in IDLE with depth 0 → mret_gnt_o = 1, no memory traffic, extra output depth_err_o pulses one cycle, no shadow_load_o.
  - Entry requested with depth 31 → entry_gnt_o = 0.
- Undefined: no counter and no depth_err_o port; mret is always filled from the stack.

Test Plan:
- XLEN = 64, next_sp_i = 0x1000−0x80 = 0xF80, entry → shadow_save_o 1 cycle; 16 writes to 0xF80, 0xF88 … 0xFF8 carrying shadow words 0..15; IDLE after the 16th rvalid.
- Fill with shadow_sp_i = 0xF80, memory returns 0xA0+i → 16 reads at 0xF80..0xFF8; shadow_we_o writes index i = 0xA0+i; shadow_load_o and mret_done_o pulse together after the last rvalid.
- mem_gnt_i stalled 5 cycles mid-spill → address and data held stable; never more than 2 outstanding; order preserved.
- entry_req_i and mret_req_i asserted together in IDLE → entry_gnt_o = 1, mret_gnt_o = 0; entry_req_i during SPILL → entry_gnt_o = 0 until IDLE.
- rst_ni dropped during FILL after 7 responses → all outputs 0 immediately; IDLE after release; no shadow_load_o.
- With SHADOW_SPILL_DEPTH_CHK_EN, mret at depth 0 → depth_err_o pulse, no mem_req_o, no shadow_load_o.
